// File: rtl/trace_pkg.sv
// trace_pkg: kind codes, FSM states and default record layout shared by the trace_retire_monitor slice
package trace_pkg;
    localparam logic [2:0] KIND_NOP   = 3'd0;
    localparam logic [2:0] KIND_REG   = 3'd1;
    localparam logic [2:0] KIND_LOAD  = 3'd2;
    localparam logic [2:0] KIND_STORE = 3'd3;
    localparam logic [2:0] KIND_HALT  = 3'd4;
    localparam int TR_DATA_W = 16;
    localparam int TR_PC_W   = 16;
    localparam int TR_CNT_W  = 32;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [2:0]           kind;
        logic [TR_CNT_W-1:0]  inum;
        logic [TR_PC_W-1:0]   pc;
        logic [3:0]           rg;
        logic [TR_DATA_W-1:0] value;
        logic [TR_PC_W-1:0]   addr;
    } trace_rec_t;
    localparam int TR_REC_W = $bits(trace_rec_t);
endpackage

// File: rtl/trace_retire_monitor_if.sv
// trace_retire_monitor_if: retire-channel inputs and record output handshake of the trace monitor
interface trace_retire_monitor_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0]        ret_valid;
    logic [NUM_CH*PC_W-1:0]   ret_pc;
    logic [NUM_CH-1:0]        ret_regwrite;
    logic [NUM_CH-1:0]        ret_memread;
    logic [NUM_CH-1:0]        ret_memwrite;
    logic [NUM_CH-1:0]        ret_halt;
    logic [NUM_CH*4-1:0]      ret_wreg;
    logic [NUM_CH*DATA_W-1:0] ret_wdata;
    logic [NUM_CH*PC_W-1:0]   ret_maddr;
    logic [NUM_CH*DATA_W-1:0] ret_mdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [2:0]               out_kind;
    logic [CNT_W-1:0]         out_inum;
    logic [PC_W-1:0]          out_pc;
    logic [3:0]               out_reg;
    logic [DATA_W-1:0]        out_value;
    logic [PC_W-1:0]          out_addr;
    modport master (
        output ret_valid, ret_pc, ret_regwrite, ret_memread, ret_memwrite, ret_halt,
               ret_wreg, ret_wdata, ret_maddr, ret_mdata, out_ready,
        input  out_valid, out_kind, out_inum, out_pc, out_reg, out_value, out_addr
    );
    modport slave (
        input  ret_valid, ret_pc, ret_regwrite, ret_memread, ret_memwrite, ret_halt,
               ret_wreg, ret_wdata, ret_maddr, ret_mdata, out_ready,
        output out_valid, out_kind, out_inum, out_pc, out_reg, out_value, out_addr
    );
endinterface

// File: rtl/trace_fifo_mw.sv
// trace_fifo_mw: FIFO taking up to NUM_CH in-order pushes per cycle and one pop, with occupancy output
module trace_fifo_mw #(
    parameter int W      = trace_pkg::TR_REC_W,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH*W-1:0] wr_data,
    input  logic [CW-1:0]       wr_cnt,
    input  logic                rd_en,
    output logic [W-1:0]        rd_data,
    output logic                empty,
    output logic [CW-1:0]       count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_CH; i++)
            if (CW'(i) < wr_cnt) mem_d[wptr_q + AW'(i)] = wr_data[i*W +: W];
        wptr_d  = wptr_q + AW'(wr_cnt);
        rptr_d  = rptr_q + AW'(rd_en);
        count_d = count_q + wr_cnt - CW'(rd_en);
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    assign empty   = count_q == '0;
    assign count   = count_q;
    // stale slot contents never leak out while the queue is empty
    assign rd_data = empty ? '0 : mem_q[rptr_q];
endmodule

// File: rtl/trace_retire_monitor.sv
// trace_retire_monitor: multi-channel retire trace capture with FIFO, watchdog and halt drain; TRACE_NOP_FILTER_EN keeps NOPs out of the FIFO
module trace_retire_monitor
    import trace_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = TR_DATA_W,
    parameter int PC_W       = TR_PC_W,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = TR_CNT_W,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    trace_retire_monitor_if.slave    bus,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         inst_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    output logic                     timeout,
    output logic                     done
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [PC_W-1:0]   pc;
        logic [3:0]        rg;
        logic [DATA_W-1:0] value;
        logic [PC_W-1:0]   addr;
    } rec_t;
    localparam int W = $bits(rec_t);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d, inst_count_q, inst_count_d, drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d, timeout_q, timeout_d;
    logic [NUM_CH*W-1:0] wr_data;
    logic [CW-1:0]     wr_cnt, n_acc, n_req, occ, free;
    logic              halt_hit, keep, empty, watchdog;
    logic [2:0]        kind;
    logic [W-1:0]      head;
    rec_t              rec, out_rec;
    // channels are walked oldest first; a halt blocks every younger channel
    always_comb begin
        wr_data  = '0;
        wr_cnt   = '0;
        n_acc    = '0;
        n_req    = '0;
        halt_hit = 1'b0;
        keep     = 1'b1;
        kind     = KIND_NOP;
        rec      = '0;
        free     = CW'(DEPTH) - occ;
        for (int i = 0; i < NUM_CH; i++) begin
            kind = bus.ret_halt[i] ? KIND_HALT :
                   bus.ret_regwrite[i] ? (bus.ret_memread[i] ? KIND_LOAD : KIND_REG) :
                   bus.ret_memwrite[i] ? KIND_STORE : KIND_NOP;
            rec.kind  = kind;
            rec.inum  = inst_count_q + CNT_W'(n_acc);
            rec.pc    = bus.ret_pc[i*PC_W +: PC_W];
            rec.rg    = (kind == KIND_REG || kind == KIND_LOAD) ? bus.ret_wreg[i*4 +: 4] : 4'd0;
            rec.value = (kind == KIND_STORE) ? bus.ret_mdata[i*DATA_W +: DATA_W] :
                        (kind == KIND_REG || kind == KIND_LOAD) ? bus.ret_wdata[i*DATA_W +: DATA_W] : '0;
            rec.addr  = (kind == KIND_LOAD || kind == KIND_STORE) ? bus.ret_maddr[i*PC_W +: PC_W] : '0;
`ifdef TRACE_NOP_FILTER_EN
            keep = kind != KIND_NOP;
`else
            keep = 1'b1;
`endif
            if (state_q == RUN && bus.ret_valid[i] && !halt_hit) begin
                n_acc = n_acc + CW'(1);
                if (keep) begin
                    if (n_req < free) begin
                        wr_data[wr_cnt*W +: W] = rec;
                        wr_cnt = wr_cnt + CW'(1);
                    end
                    n_req = n_req + CW'(1);
                end
                halt_hit = bus.ret_halt[i];
            end
        end
    end
    always_comb begin
        watchdog      = state_q == RUN && cycle_count_q == CNT_W'(MAX_CYCLES);
        state_d       = (state_q == RUN) ? ((halt_hit || watchdog) ? DRAIN : RUN) :
                        (state_q == DRAIN && empty) ? DONE : state_q;
        cycle_count_d = (state_q == DONE || &cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
        inst_count_d  = inst_count_q + CNT_W'(n_acc);
        drop_count_d  = drop_count_q + CNT_W'(n_req - wr_cnt);
        overflow_d    = overflow_q | (n_req != wr_cnt);
        timeout_d     = timeout_q | watchdog;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            cycle_count_q <= '0;
            inst_count_q  <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            inst_count_q  <= inst_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
        end
    end
    trace_fifo_mw #(.W(W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (wr_data),
        .wr_cnt  (wr_cnt),
        .rd_en   (!empty && bus.out_ready),
        .rd_data (head),
        .empty   (empty),
        .count   (occ)
    );
    assign out_rec       = rec_t'(head);
    assign bus.out_valid = !empty;
    assign bus.out_kind  = out_rec.kind;
    assign bus.out_inum  = out_rec.inum;
    assign bus.out_pc    = out_rec.pc;
    assign bus.out_reg   = out_rec.rg;
    assign bus.out_value = out_rec.value;
    assign bus.out_addr  = out_rec.addr;
    assign cycle_count   = cycle_count_q;
    assign inst_count    = inst_count_q;
    assign drop_count    = drop_count_q;
    assign overflow      = overflow_q;
    assign timeout       = timeout_q;
    assign done          = state_q == DONE;
endmodule

// File: tb/tb_trace_retire_monitor.sv
// tb_trace_retire_monitor: directed vectors with hand-computed expectations for trace_retire_monitor
module tb_trace_retire_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cycle_count, inst_count, drop_count;
    logic        overflow, timeout, done;
    int          n_run = 0;
    int          n_fail = 0;
    trace_retire_monitor_if #(.NUM_CH(2), .DATA_W(16), .PC_W(16), .CNT_W(32)) bus();
    trace_retire_monitor #(
        .NUM_CH(2), .DATA_W(16), .PC_W(16), .DEPTH(16), .CNT_W(32), .MAX_CYCLES(50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cycle_count (cycle_count),
        .inst_count  (inst_count),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .timeout     (timeout),
        .done        (done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle;
        bus.ret_valid    = '0;
        bus.ret_pc       = '0;
        bus.ret_regwrite = '0;
        bus.ret_memread  = '0;
        bus.ret_memwrite = '0;
        bus.ret_halt     = '0;
        bus.ret_wreg     = '0;
        bus.ret_wdata    = '0;
        bus.ret_maddr    = '0;
        bus.ret_mdata    = '0;
    endtask
    task automatic drive(input int ch, input logic [15:0] pc, input logic rw, input logic mr,
                         input logic mw, input logic h, input logic [3:0] wreg,
                         input logic [15:0] wdata, input logic [15:0] maddr, input logic [15:0] mdata);
        bus.ret_valid[ch]         = 1'b1;
        bus.ret_pc[ch*16 +: 16]   = pc;
        bus.ret_regwrite[ch]      = rw;
        bus.ret_memread[ch]       = mr;
        bus.ret_memwrite[ch]      = mw;
        bus.ret_halt[ch]          = h;
        bus.ret_wreg[ch*4 +: 4]   = wreg;
        bus.ret_wdata[ch*16 +: 16] = wdata;
        bus.ret_maddr[ch*16 +: 16] = maddr;
        bus.ret_mdata[ch*16 +: 16] = mdata;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        idle();
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        // reset state
        do_reset();
        check("rst_valid", bus.out_valid, 0);
        check("rst_kind", bus.out_kind, 0);
        check("rst_inum", bus.out_inum, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_inst", inst_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_tmo", timeout, 0);
        check("rst_done", done, 0);
        // REG + STORE in one cycle
        bus.out_ready = 1'b1;
        drive(0, 16'h0002, 1, 0, 0, 0, 4'd3, 16'h00AB, 16'h0000, 16'h0000);
        drive(1, 16'h0004, 0, 0, 1, 0, 4'd6, 16'h7777, 16'h0010, 16'h1234);
        tick();
        idle();
        check("t1_valid", bus.out_valid, 1);
        check("t1_kind", bus.out_kind, 1);
        check("t1_inum", bus.out_inum, 0);
        check("t1_pc", bus.out_pc, 16'h0002);
        check("t1_reg", bus.out_reg, 3);
        check("t1_value", bus.out_value, 16'h00AB);
        check("t1_addr", bus.out_addr, 0);
        check("t1_inst", inst_count, 2);
        check("t1_cycles", cycle_count, 1);
        tick();
        check("t1_st_kind", bus.out_kind, 3);
        check("t1_st_inum", bus.out_inum, 1);
        check("t1_st_pc", bus.out_pc, 16'h0004);
        check("t1_st_reg", bus.out_reg, 0);
        check("t1_st_value", bus.out_value, 16'h1234);
        check("t1_st_addr", bus.out_addr, 16'h0010);
        tick();
        check("t1_empty", bus.out_valid, 0);
        // LOAD then NOP
        drive(0, 16'h0006, 1, 1, 0, 0, 4'd5, 16'h0F0F, 16'h0040, 16'h0000);
        tick();
        idle();
        drive(0, 16'h0008, 0, 0, 0, 0, 4'd9, 16'hDEAD, 16'h0077, 16'h0099);
        check("t2_ld_kind", bus.out_kind, 2);
        check("t2_ld_inum", bus.out_inum, 2);
        check("t2_ld_addr", bus.out_addr, 16'h0040);
        check("t2_ld_reg", bus.out_reg, 5);
        check("t2_ld_value", bus.out_value, 16'h0F0F);
        tick();
        idle();
`ifdef TRACE_NOP_FILTER_EN
        check("t2_nop_filtered", bus.out_valid, 0);
`else
        check("t2_nop_valid", bus.out_valid, 1);
        check("t2_nop_kind", bus.out_kind, 0);
        check("t2_nop_inum", bus.out_inum, 3);
        check("t2_nop_reg", bus.out_reg, 0);
        check("t2_nop_value", bus.out_value, 0);
        check("t2_nop_addr", bus.out_addr, 0);
`endif
        check("t2_inst", inst_count, 4);
        // overflow: 18 records into 16 slots, the last pair dropped
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(0, 16'(c*4), 1, 0, 0, 0, 4'd1, 16'(2*c), 16'h0, 16'h0);
            drive(1, 16'(c*4+2), 1, 0, 0, 0, 4'd2, 16'(2*c+1), 16'h0, 16'h0);
            tick();
        end
        idle();
        check("t3_inst", inst_count, 18);
        check("t3_drop", drop_count, 2);
        check("t3_ovf", overflow, 1);
        check("t3_valid", bus.out_valid, 1);
        check("t3_hold_inum", bus.out_inum, 0);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("t3_drain%0d_inum", j), bus.out_inum, 64'(j));
            check($sformatf("t3_drain%0d_value", j), bus.out_value, 64'(j));
            tick();
        end
        check("t3_empty", bus.out_valid, 0);
        // halt in ch0 masks ch1, then drain to DONE
        do_reset();
        drive(0, 16'h0020, 1, 0, 0, 1, 4'd7, 16'hBEEF, 16'h0000, 16'h0000);
        drive(1, 16'h0022, 1, 0, 0, 0, 4'd2, 16'h0001, 16'h0000, 16'h0000);
        tick();
        idle();
        check("t4_inst", inst_count, 1);
        check("t4_kind", bus.out_kind, 4);
        check("t4_pc", bus.out_pc, 16'h0020);
        check("t4_reg", bus.out_reg, 0);
        check("t4_value", bus.out_value, 0);
        check("t4_done0", done, 0);
        drive(0, 16'h0024, 1, 0, 0, 0, 4'd1, 16'h0001, 16'h0000, 16'h0000);
        tick();
        idle();
        check("t4_drain_ignore", inst_count, 1);
        check("t4_drain_head", bus.out_kind, 4);
        bus.out_ready = 1'b1;
        tick();
        check("t4_popped", bus.out_valid, 0);
        check("t4_done_wait", done, 0);
        tick();
        check("t4_done", done, 1);
        drive(0, 16'h0026, 1, 0, 0, 0, 4'd1, 16'h0001, 16'h0000, 16'h0000);
        tick();
        idle();
        check("t4_done_inst", inst_count, 1);
        check("t4_done_valid", bus.out_valid, 0);
        check("t4_done_hold", done, 1);
        // watchdog
        do_reset();
        bus.out_ready = 1'b1;
        repeat (50) tick();
        check("t5_cyc50", cycle_count, 50);
        check("t5_tmo_pre", timeout, 0);
        tick();
        check("t5_cyc51", cycle_count, 51);
        check("t5_tmo", timeout, 1);
        check("t5_not_done", done, 0);
        tick();
        check("t5_done", done, 1);
        check("t5_cyc52", cycle_count, 52);
        repeat (3) tick();
        check("t5_cyc_frozen", cycle_count, 52);
        // reset while draining with 5 entries queued
        do_reset();
        drive(0, 16'h0100, 1, 0, 0, 0, 4'd1, 16'h0001, 16'h0000, 16'h0000);
        drive(1, 16'h0102, 1, 0, 0, 0, 4'd2, 16'h0002, 16'h0000, 16'h0000);
        tick();
        drive(0, 16'h0104, 1, 0, 0, 0, 4'd3, 16'h0003, 16'h0000, 16'h0000);
        drive(1, 16'h0106, 1, 0, 0, 0, 4'd4, 16'h0004, 16'h0000, 16'h0000);
        tick();
        idle();
        drive(0, 16'h0108, 0, 0, 0, 1, 4'd0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        idle();
        tick();
        check("t6_pre_valid", bus.out_valid, 1);
        check("t6_pre_inst", inst_count, 5);
        rst = 1'b1;
        tick();
        check("t6_valid", bus.out_valid, 0);
        check("t6_inum", bus.out_inum, 0);
        check("t6_kind", bus.out_kind, 0);
        check("t6_value", bus.out_value, 0);
        check("t6_cycles", cycle_count, 0);
        check("t6_inst", inst_count, 0);
        check("t6_drop", drop_count, 0);
        check("t6_tmo", timeout, 0);
        check("t6_done", done, 0);
        rst = 1'b0;
        tick();
        check("t6_run_cycles", cycle_count, 1);
        check("t6_run_empty", bus.out_valid, 0);
        // four NOPs then one REG
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(0, 16'(16'h0200 + c*4), 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0);
            drive(1, 16'(16'h0202 + c*4), 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0);
            tick();
        end
        idle();
        drive(0, 16'h0030, 1, 0, 0, 0, 4'd1, 16'h0055, 16'h0000, 16'h0000);
        tick();
        idle();
        check("t7_inst", inst_count, 5);
`ifdef TRACE_NOP_FILTER_EN
        check("t7_valid", bus.out_valid, 1);
        check("t7_inum", bus.out_inum, 4);
        check("t7_kind", bus.out_kind, 1);
        check("t7_value", bus.out_value, 16'h0055);
        bus.out_ready = 1'b1;
        tick();
        check("t7_single", bus.out_valid, 0);
`else
        check("t7_head_kind", bus.out_kind, 0);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check($sformatf("t7_rec%0d_inum", j), bus.out_inum, 64'(j));
            tick();
        end
        check("t7_empty", bus.out_valid, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/trace_retire_monitor.md
Name: trace_retire_monitor

Overview:
- Synthesizable retirement-trace capture unit for the 16-bit WISC core family.
- Generalises the single-issue cycle/instruction logging to NUM_CH retire channels per cycle.
- Classifies each retire event (reg write, load, store, NOP/branch, halt) and numbers it.
- Buffers records in a FIFO drained over a valid/ready port, with cycle watchdog and halt-drain FSM; sits beside cpu, fed from the writeback/memory stages.

Parameters:
- NUM_CH, 2, retire channels per cycle (1..4); channel 0 is oldest.
- DATA_W, 16, register/memory data width.
- PC_W, 16, PC and memory address width.
- DEPTH, 16, FIFO entries; power of two, at least NUM_CH.
- CNT_W, 32, width of the cycle, instruction and drop counters.
- MAX_CYCLES, 100000, watchdog limit.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ret_valid  in  NUM_CH  channel i retired an instruction this cycle.
- ret_pc  in  NUM_CH*PC_W  retiring PC, channel i at [i*PC_W +: PC_W].
- ret_regwrite, ret_memread, ret_memwrite, ret_halt  in  NUM_CH each  per-channel control.
- ret_wreg  in  NUM_CH*4  destination register.
- ret_wdata  in  NUM_CH*DATA_W  register write data.
- ret_maddr  in  NUM_CH*PC_W  memory address.
- ret_mdata  in  NUM_CH*DATA_W  store data.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts record.
- out_kind  out  3  0 NOP, 1 REG, 2 LOAD, 3 STORE, 4 HALT.
- out_inum, out_pc, out_reg, out_value, out_addr  out  CNT_W, PC_W, 4, DATA_W, PC_W  record fields.
- cycle_count, inst_count, drop_count  out  CNT_W each  counters.
- overflow  out  1  sticky; set on any dropped record.
- timeout  out  1  sticky; set when the watchdog fires.
- done  out  1  FSM in DONE.

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in RUN.
- Record kind priority per channel:
  - halt gives HALT;
  - else regwrite gives LOAD if memread, otherwise REG;
  - else memwrite gives STORE;
  - else NOP.
- Unused fields are 0: REG/NOP have addr=0; STORE has reg=0 and value=mdata; HALT has pc only.
- Numbering: the k-th valid channel this cycle (k from 0, in channel order) gets inum = inst_count + k. inst_count advances by the number of accepted valid channels. Numbering is independent of FIFO drops.
- Halt in channel h: channels above h in the same cycle are ignored (not numbered, not counted). The FSM moves to DRAIN the next cycle.
- FSM states:
  - RUN accepts retires.
  - DRAIN ignores ret_*; when the FIFO is empty, moves to DONE.
  - DONE is terminal until reset; done=1.
- Watchdog: cycle_count increments every cycle in RUN and DRAIN and saturates at all-ones. When cycle_count == MAX_CYCLES in RUN: timeout=1 and the FSM goes to DRAIN.
- FIFO:
  - free = DEPTH - occupancy at the start of the cycle; a same-cycle pop is not credited.
  - Records are pushed in channel order until free is exhausted. The rest are dropped: drop_count += dropped, overflow=1.
  - Pop occurs when out_valid && out_ready.
  - Pointers wrap modulo DEPTH.
- Latency: a record pushed in cycle t is visible on out_* at t+1 if it is at the head. out_* hold stable while out_valid && !out_ready.
- Reset mid-operation clears everything, including sticky flags and counters.

Optional Feature:
- Macro: TRACE_NOP_FILTER_EN.
- Defined: NOP records are not pushed and consume no FIFO slot. They are still numbered and still counted in inst_count.
- Undefined: NOP records are pushed like any other kind.

Decomposition:
- Package trace_pkg:
  - kind encodings KIND_NOP..KIND_HALT;
  - FSM state enum RUN/DRAIN/DONE;
  - record struct type and its width constant.
- One sub-module: trace_fifo_mw, a multi-write (up to NUM_CH pushes per cycle), single-read FIFO with occupancy output.
- Classification, numbering and the FSM stay in the top module.

Test Plan:
- NUM_CH=2, cycle 1: ch0 REG r3=0x00AB pc=0x0002, ch1 STORE addr=0x0010 data=0x1234, out_ready=1 → records inum 0 (kind 1) and inum 1 (kind 3) on consecutive cycles; inst_count=2.
- ch0 regwrite+memread r5=0x0F0F addr=0x0040 → kind 2, addr 0x0040; ch0 valid with no flags → kind 0, inum advances.
- out_ready=0, 2 records/cycle for 9 cycles, DEPTH=16 → 16 stored, drop_count=2, overflow=1; with ready raised, the 16 records drain in order with contiguous inum except the dropped pair.
- ch0 HALT pc=0x0020 with ch1 REG in the same cycle → ch1 ignored; FSM goes DRAIN then DONE after the FIFO empties; done=1; later ret_valid ignored.
- MAX_CYCLES=50, no halt → timeout=1 at cycle 50; done once empty; cycle_count stops changing in DONE.
- Assert rst while in DRAIN with 5 entries queued → next cycle all outputs 0 and FIFO empty; with TRACE_NOP_FILTER_EN, 4 NOPs plus 1 REG give a single record with inum 4.
